// File: rtl/proc_pkg.sv
// Constants shared between the fetch queue and the processor core.
// The queue entry layout lives here so both sides agree on field order.
package proc_pkg;

    localparam int PC_W    = 10;
    localparam int INSTR_W = 16;
    localparam int ENTRY_W = INSTR_W + PC_W;

    localparam logic [PC_W-1:0] DEFAULT_RESET_PC = 10'd0;
    localparam logic [PC_W-1:0] PC_ONE           = 10'd1;

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [PC_W-1:0]    pc;
    } fq_entry_t;

    // Wraps 1023 -> 0 silently; there is no overflow flag.
    function automatic logic [PC_W-1:0] pc_inc(input logic [PC_W-1:0] pc);
        return pc + PC_ONE;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Circular-buffer FIFO with a flush that empties it in one cycle.
// Occupancy is tracked by count, so head == tail is never used to tell full from empty.
module sync_fifo #(
    parameter int WIDTH = 26,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    head_reg, head_next;
    logic [AW-1:0]    tail_reg, tail_next;
    logic [AW:0]      count_reg, count_next;
    logic             wr_ok, rd_ok;

    // Guard against overrun/underrun even if the caller misqualifies.
    assign wr_ok = wr_en && !flush && (count_reg != FULL_COUNT);
    assign rd_ok = rd_en && !flush && (count_reg != '0);

    always_comb begin
        head_next  = head_reg;
        tail_next  = tail_reg;
        count_next = count_reg;
        if (flush) begin
            head_next  = '0;
            tail_next  = '0;
            count_next = '0;
        end else begin
            if (wr_ok) tail_next = tail_reg + AW'(1);
            if (rd_ok) head_next = head_reg + AW'(1);
            case ({wr_ok, rd_ok})
                2'b10:   count_next = count_reg + (AW+1)'(1);
                2'b01:   count_next = count_reg - (AW+1)'(1);
                default: count_next = count_reg;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head_reg  <= '0;
            tail_reg  <= '0;
            count_reg <= '0;
        end else begin
            head_reg  <= head_next;
            tail_reg  <= tail_next;
            count_reg <= count_next;
        end
    end

    // Storage is never cleared; stale slots are unreachable once count says so.
    always_ff @(posedge clk) begin
        if (wr_ok) mem[tail_reg] <= wr_data;
    end

    assign rd_data = mem[head_reg];
    assign count   = count_reg;

endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch queue: owns the fetch pointer, qualifies enqueue/dequeue,
// and gives redirects absolute priority over fetch and decode handshakes.
module fetch_queue
    import proc_pkg::*;
#(
    parameter int              DEPTH    = 4,
    parameter logic [PC_W-1:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     fetch_enable,
    output logic [PC_W-1:0]          imem_addr,
    input  logic [INSTR_W-1:0]       imem_data,
    output logic                     instr_valid,
    input  logic                     instr_ready,
    output logic [INSTR_W-1:0]       instr_data,
    output logic [PC_W-1:0]          instr_pc,
    input  logic                     redirect_valid,
    input  logic [PC_W-1:0]          redirect_pc,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    logic [PC_W-1:0] fetch_pc_reg, fetch_pc_next;
    logic            enq, deq;
    fq_entry_t       wr_entry, rd_entry;
    logic [CW-1:0]   fifo_count;

    // No fetch-through-full: a full queue stalls fetch even if decode drains this cycle.
    assign enq = fetch_enable && (fifo_count != FULL_COUNT) && !redirect_valid;
    assign deq = instr_valid && instr_ready && !redirect_valid;

    always_comb begin
        fetch_pc_next = fetch_pc_reg;
        if (redirect_valid)
            fetch_pc_next = redirect_pc;
        else if (enq)
            fetch_pc_next = pc_inc(fetch_pc_reg);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            fetch_pc_reg <= RESET_PC;
        else
            fetch_pc_reg <= fetch_pc_next;
    end

    assign wr_entry.instr = imem_data;
    assign wr_entry.pc    = fetch_pc_reg;

    sync_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .flush   (redirect_valid),
        .wr_en   (enq),
        .wr_data (wr_entry),
        .rd_en   (deq),
        .rd_data (rd_entry),
        .count   (fifo_count)
    );

    assign imem_addr   = fetch_pc_reg;
    assign instr_valid = (fifo_count != '0);
    assign instr_data  = rd_entry.instr;
    assign instr_pc    = rd_entry.pc;
    assign count       = fifo_count;

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: hand-derived vector table plus a queue scoreboard
// that predicts every accepted instruction and the occupancy each cycle.
module tb_fetch_queue;
    import proc_pkg::*;

    localparam int DEPTH = 4;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 fetch_enable;
    logic [PC_W-1:0]      imem_addr;
    logic [INSTR_W-1:0]   imem_data;
    logic                 instr_valid;
    logic                 instr_ready;
    logic [INSTR_W-1:0]   instr_data;
    logic [PC_W-1:0]      instr_pc;
    logic                 redirect_valid;
    logic [PC_W-1:0]      redirect_pc;
    logic [2:0]           count;

    always #5 clk = ~clk;

    function automatic logic [INSTR_W-1:0] mem_word(input logic [PC_W-1:0] a);
        return {a[5:0] ^ 6'h2b, a};
    endfunction

    assign imem_data = mem_word(imem_addr);

    fetch_queue #(.DEPTH(DEPTH), .RESET_PC(10'd0)) dut (
        .clk            (clk),
        .reset          (reset),
        .fetch_enable   (fetch_enable),
        .imem_addr      (imem_addr),
        .imem_data      (imem_data),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr_data     (instr_data),
        .instr_pc       (instr_pc),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .count          (count)
    );

    typedef struct {
        logic            fe;
        logic            rdy;
        logic            rv;
        logic [PC_W-1:0] rpc;
        int              exp_cnt;
        int              exp_addr;
        int              exp_head;
    } vec_t;

    vec_t                  vecs[$];
    logic [ENTRY_W-1:0]    sb[$];
    logic [PC_W-1:0]       model_pc;
    int                    checks = 0;
    int                    errors = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic add_vec(input logic fe, input logic rdy, input logic rv, input int rpc,
                           input int cnt, input int addr, input int head);
        vec_t v;
        v.fe = fe; v.rdy = rdy; v.rv = rv; v.rpc = PC_W'(rpc);
        v.exp_cnt = cnt; v.exp_addr = addr; v.exp_head = head;
        vecs.push_back(v);
    endtask

    // One clock: drive at negedge, score the handshake, advance the model, check after the edge.
    task automatic cycle(input logic fe, input logic rdy, input logic rv, input logic [PC_W-1:0] rpc);
        logic do_enq;
        fetch_enable   = fe;
        instr_ready    = rdy;
        redirect_valid = rv;
        redirect_pc    = rpc;
        #1;
        if (rdy && !rv && sb.size() != 0) begin
            check("deq_pc", int'(instr_pc), int'(sb[0][PC_W-1:0]));
            check("deq_data", int'(instr_data), int'(sb[0][ENTRY_W-1:PC_W]));
            $display("deq pc=%0d data=%h", instr_pc, instr_data);
        end
        if (rv) begin
            sb.delete();
            model_pc = rpc;
        end else begin
            do_enq = fe && (sb.size() < DEPTH);
            if (rdy && sb.size() != 0) void'(sb.pop_front());
            if (do_enq) begin
                sb.push_back({mem_word(model_pc), model_pc});
                model_pc = model_pc + 10'd1;
            end
        end
        @(posedge clk);
        @(negedge clk);
        check("sb_count", int'(count), sb.size());
        check("sb_valid", int'(instr_valid), int'(sb.size() != 0));
        check("sb_addr", int'(imem_addr), int'(model_pc));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        // Fill from reset, then steady streaming with a full-queue stall.
        for (int i = 1; i <= 4; i++) add_vec(1, 0, 0, 0, i, i, 0);
        add_vec(1, 0, 0, 0, 4, 4, 0);
        add_vec(1, 1, 0, 0, 3, 4, 1);
        for (int k = 2; k <= 10; k++) add_vec(1, 1, 0, 0, 3, k + 3, k);
        // Redirects, including wrap past 1023.
        add_vec(1, 1, 1, 100,  0, 100,  0);
        add_vec(1, 1, 0, 0,    1, 101,  100);
        add_vec(1, 1, 0, 0,    1, 102,  101);
        add_vec(1, 1, 1, 1022, 0, 1022, 0);
        add_vec(1, 1, 0, 0,    1, 1023, 1022);
        add_vec(1, 1, 0, 0,    1, 0,    1023);
        add_vec(1, 1, 0, 0,    1, 1,    0);
        add_vec(1, 1, 0, 0,    1, 2,    1);
        // Drain with fetch disabled.
        add_vec(1, 0, 0, 0, 2, 3, 1);
        add_vec(0, 1, 0, 0, 1, 3, 2);
        add_vec(0, 1, 0, 0, 0, 3, 0);
        add_vec(0, 1, 0, 0, 0, 3, 0);

        reset = 1'b1;
        fetch_enable = 1'b0; instr_ready = 1'b0;
        redirect_valid = 1'b0; redirect_pc = '0;
        repeat (2) @(negedge clk);
        check("reset_count", int'(count), 0);
        check("reset_valid", int'(instr_valid), 0);
        check("reset_addr", int'(imem_addr), 0);
        reset = 1'b0;
        model_pc = 10'd0;

        foreach (vecs[i]) begin
            cycle(vecs[i].fe, vecs[i].rdy, vecs[i].rv, vecs[i].rpc);
            check($sformatf("vec%0d_count", i), int'(count), vecs[i].exp_cnt);
            check($sformatf("vec%0d_addr", i), int'(imem_addr), vecs[i].exp_addr);
            if (vecs[i].exp_cnt != 0)
                check($sformatf("vec%0d_head", i), int'(instr_pc), vecs[i].exp_head);
            $display("vec %0d count=%0d addr=%0d valid=%0d head=%0d",
                     i, count, imem_addr, instr_valid, instr_pc);
        end

        // Asynchronous reset in the middle of a cycle with three entries queued.
        repeat (3) cycle(1, 0, 0, 10'd0);
        check("pre_reset_count", int'(count), 3);
        fetch_enable = 1'b1; instr_ready = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        check("async_reset_count", int'(count), 0);
        check("async_reset_valid", int'(instr_valid), 0);
        check("async_reset_addr", int'(imem_addr), 0);
        $display("async reset count=%0d valid=%0d addr=%0d", count, instr_valid, imem_addr);
        sb.delete();
        model_pc = 10'd0;
        @(posedge clk);
        @(negedge clk);
        check("held_reset_count", int'(count), 0);
        reset = 1'b0;
        repeat (2) cycle(0, 0, 0, 10'd0);
        cycle(1, 0, 0, 10'd0);
        check("first_fetch_count", int'(count), 1);
        check("first_fetch_head", int'(instr_pc), 0);

        // Randomised traffic against the scoreboard.
        for (int n = 0; n < 400; n++) begin
            logic [PC_W-1:0] rpc;
            rpc = ($urandom_range(0, 3) == 0) ? 10'd1023 : PC_W'($urandom_range(0, 1023));
            cycle($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
                  $urandom_range(0, 19) == 0, rpc);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
